// File: rtl/score_digits_pkg.sv
// Shared types and defaults for the score digit renderer.
// Widths here are fixed by the glyph bitmap and the game-logic score bus.
package score_digits_pkg;
    localparam int SCORE_W        = 14;
    localparam int PIX_W          = 11;
    localparam int NUM_DIGITS_DEF = 4;
    localparam int DIGIT_W_DEF    = 8;
    localparam int DIGIT_H_DEF    = 16;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_t;

    function automatic bcd_t add3(input bcd_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction
endpackage

// File: rtl/score_digits_controller_if.sv
// Game-logic/video-side signals of the score digit controller.
// master = surrounding logic, slave = controller.
interface score_digits_if;
    import score_digits_pkg::*;

    logic             startOfFrame;
    logic             scoreLoad;
    logic [SCORE_W-1:0] score;
    logic [PIX_W-1:0] pixelX;
    logic [PIX_W-1:0] pixelY;
    bcd_t             digit;
    logic [PIX_W-1:0] offsetX;
    logic [PIX_W-1:0] offsetY;
    logic             InsideRectangle;
    logic             busy;
    logic             overflow;

    modport master (
        output startOfFrame, scoreLoad, score, pixelX, pixelY,
        input  digit, offsetX, offsetY, InsideRectangle, busy, overflow
    );

    modport slave (
        input  startOfFrame, scoreLoad, score, pixelX, pixelY,
        output digit, offsetX, offsetY, InsideRectangle, busy, overflow
    );
endinterface

// File: rtl/score_digits_controller_bin2bcd_seq.sv
// Iterative binary-to-BCD (shift-add-3), one bit per clock; SCORE_W cycles in CONV plus one DONE cycle.
// A new start is accepted in IDLE or DONE, never mid-conversion.
module bin2bcd_seq
    import score_digits_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [SCORE_W-1:0] i_bin,
    output logic               o_busy,
    output logic               o_done,
    output bcd_t               o_bcd [NUM_DIGITS]
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SCORE_W);

    conv_state_t        r_state;
    conv_state_t        w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0] r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_adj;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = CONV;
            CONV:    if (r_cnt == CNT_W'(SCORE_W - 1)) w_next = DONE;
            DONE:    w_next = i_start ? CONV : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            w_adj[4*i +: 4] = add3(r_bcd[4*i +: 4]);
    end

    // The adjusted MSB is always shifted out: saturated inputs never reach it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (i_start && r_state != CONV) begin
            r_bin <= i_bin;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (r_state == CONV) begin
            r_bcd <= BCD_W'({w_adj, r_bin[SCORE_W-1]});
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == DONE);

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++)
            o_bcd[i] = r_bcd[4*(NUM_DIGITS-1-i) +: 4];
    end
endmodule

// File: rtl/score_digits_controller.sv
// Score loader (saturate, 1-deep pending, frame-aligned commit) plus registered pixel-to-cell mapper.
// Pixel outputs lag pixelX/pixelY by one cycle; loads while busy park in the pending register.
module score_digits_controller
    import score_digits_pkg::*;
#(
    parameter int               NUM_DIGITS = NUM_DIGITS_DEF,
    parameter logic [PIX_W-1:0] TOPLEFT_X  = 11'd20,
    parameter logic [PIX_W-1:0] TOPLEFT_Y  = 11'd10,
    parameter int               DIGIT_W    = DIGIT_W_DEF,
    parameter int               DIGIT_H    = DIGIT_H_DEF,
    parameter bit               BLANK_LEAD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    score_digits_if.slave sd
);
    localparam int                 MAX_SCORE = 10**NUM_DIGITS - 1;
    localparam logic [SCORE_W-1:0] MAX_S     = SCORE_W'(MAX_SCORE);
    localparam int                 XS        = $clog2(DIGIT_W);
    localparam int                 IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic               w_ovf, w_busy, w_done, w_accept, w_start, w_active, w_seen;
    logic [SCORE_W-1:0] w_sat, w_start_bin;
    bcd_t               w_bcd [NUM_DIGITS];
    logic               w_vis [NUM_DIGITS];
    logic [PIX_W-1:0]   w_rel_x, w_rel_y;
    logic [IDX_W-1:0]   w_idx;

    logic [SCORE_W-1:0] r_pend;
    logic               r_pend_vld, r_ovf, r_res_vld, r_inside;
    bcd_t               r_res  [NUM_DIGITS];
    bcd_t               r_disp [NUM_DIGITS];
    bcd_t               r_digit;
    logic [PIX_W-1:0]   r_off_x, r_off_y;

    assign w_ovf       = (sd.score > MAX_S);
    assign w_sat       = w_ovf ? MAX_S : sd.score;
    assign w_accept    = !w_busy || w_done;
    assign w_start     = w_accept && (sd.scoreLoad || r_pend_vld);
    assign w_start_bin = sd.scoreLoad ? w_sat : r_pend;

    bin2bcd_seq #(.NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
        .clk     (clk),
        .rst     (reset),
        .i_start (w_start),
        .i_bin   (w_start_bin),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    // A strobe seen together with a pending value overrides it (latest wins).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (sd.scoreLoad) r_ovf <= w_ovf;
            if (sd.scoreLoad && !w_accept) begin
                r_pend     <= w_sat;
                r_pend_vld <= 1'b1;
            end else if (w_start) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_vld <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_res[i]  <= '0;
                r_disp[i] <= '0;
            end
        end else if (sd.startOfFrame && (r_res_vld || w_done)) begin
            r_res_vld <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++)
                r_disp[i] <= w_done ? w_bcd[i] : r_res[i];
        end else if (w_done) begin
            r_res_vld <= 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++)
                r_res[i] <= w_bcd[i];
        end
    end

    assign w_rel_x  = sd.pixelX - TOPLEFT_X;
    assign w_rel_y  = sd.pixelY - TOPLEFT_Y;
    assign w_active = (w_rel_x < PIX_W'(NUM_DIGITS * DIGIT_W)) && (w_rel_y < PIX_W'(DIGIT_H));
    assign w_idx    = w_rel_x[XS +: IDX_W];

    // Cell i is visible once any digit at or left of it is nonzero; units always shows.
    always_comb begin
        w_seen = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_seen   = w_seen | (r_disp[i] != '0) | (i == NUM_DIGITS - 1);
            w_vis[i] = w_seen | ~BLANK_LEAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit  <= '0;
            r_off_x  <= '0;
            r_off_y  <= '0;
            r_inside <= 1'b0;
        end else if (w_active) begin
            r_digit  <= r_disp[w_idx];
            r_off_x  <= w_rel_x & PIX_W'(DIGIT_W - 1);
            r_off_y  <= w_rel_y;
            r_inside <= w_vis[w_idx];
        end else begin
            r_digit  <= '0;
            r_off_x  <= '0;
            r_off_y  <= '0;
            r_inside <= 1'b0;
        end
    end

    assign sd.digit           = r_digit;
    assign sd.offsetX         = r_off_x;
    assign sd.offsetY         = r_off_y;
    assign sd.InsideRectangle = r_inside;
    assign sd.busy            = w_busy;
    assign sd.overflow        = r_ovf;
endmodule

// File: tb/tb_score_digits_controller.sv
// Randomized and directed bench for score_digits_controller against a decimal/edge-count reference model.
module tb_score_digits_controller;
    import score_digits_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_digits_if sd ();

    score_digits_controller dut (
        .clk   (clk),
        .reset (reset),
        .sd    (sd)
    );

    int checks = 0;
    int errors = 0;

    // reference model state (plain integers, times in edge numbers)
    int edge_n;
    int m_disp, m_res_val, m_job_val, m_job_end, m_pend_val;
    bit m_res_vld, m_job_act, m_pend_vld, m_ovf;
    int e_digit, e_offx, e_offy, e_ins, e_busy, e_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic int sat(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    task automatic model_reset();
        m_disp = 0; m_res_val = 0; m_res_vld = 0; m_job_act = 0;
        m_job_val = 0; m_job_end = 0; m_pend_val = 0; m_pend_vld = 0; m_ovf = 0;
        e_digit = 0; e_offx = 0; e_offy = 0; e_ins = 0; e_busy = 0; e_ovf = 0;
    endtask

    task automatic model_edge();
        int rx, ry, idx;
        bit done_now, accept;
        edge_n++;
        if (reset) begin
            model_reset();
            return;
        end
        rx = (int'(sd.pixelX) - 20) & 2047;
        ry = (int'(sd.pixelY) - 10) & 2047;
        if (rx < 32 && ry < 16) begin
            idx     = rx / 8;
            e_digit = (m_disp / pow10(3 - idx)) % 10;
            e_offx  = rx % 8;
            e_offy  = ry;
            e_ins   = (idx == 3 || m_disp >= pow10(3 - idx)) ? 1 : 0;
        end else begin
            e_digit = 0; e_offx = 0; e_offy = 0; e_ins = 0;
        end
        done_now = m_job_act && (edge_n == m_job_end);
        accept   = !m_job_act || done_now;
        if (sd.startOfFrame && (m_res_vld || done_now)) begin
            m_disp    = done_now ? m_job_val : m_res_val;
            m_res_vld = 0;
        end else if (done_now) begin
            m_res_val = m_job_val;
            m_res_vld = 1;
        end
        if (sd.scoreLoad) m_ovf = (int'(sd.score) > 9999);
        if (accept && (sd.scoreLoad || m_pend_vld)) begin
            m_job_val  = sd.scoreLoad ? sat(int'(sd.score)) : m_pend_val;
            m_job_act  = 1;
            m_job_end  = edge_n + 15;
            m_pend_vld = 0;
        end else begin
            if (done_now) m_job_act = 0;
            if (sd.scoreLoad) begin
                m_pend_val = sat(int'(sd.score));
                m_pend_vld = 1;
            end
        end
        e_busy = m_job_act ? 1 : 0;
        e_ovf  = m_ovf ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("busy",     32'(sd.busy),            e_busy);
        chk("overflow", 32'(sd.overflow),        e_ovf);
        chk("digit",    32'(sd.digit),           e_digit);
        chk("offsetX",  32'(sd.offsetX),         e_offx);
        chk("offsetY",  32'(sd.offsetY),         e_offy);
        chk("inside",   32'(sd.InsideRectangle), e_ins);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic load(input int v);
        sd.scoreLoad = 1'b1;
        sd.score     = 14'(v);
        tick();
        sd.scoreLoad = 1'b0;
    endtask

    task automatic frame();
        sd.startOfFrame = 1'b1;
        tick();
        sd.startOfFrame = 1'b0;
    endtask

    task automatic pix_cell(input int k);
        sd.pixelX = 11'(20 + 8 * k + 2);
        sd.pixelY = 11'(10 + 5);
        tick();
    endtask

    initial begin
        int bc;
        edge_n = 0;
        model_reset();
        reset = 1'b1;
        sd.startOfFrame = 1'b0; sd.scoreLoad = 1'b0; sd.score = '0;
        sd.pixelX = 11'd25; sd.pixelY = 11'd12;
        run(2);
        chk("rst_digit",  32'(sd.digit), 0);
        chk("rst_inside", 32'(sd.InsideRectangle), 0);
        chk("rst_busy",   32'(sd.busy), 0);
        chk("rst_ovf",    32'(sd.overflow), 0);
        reset = 1'b0;
        run(2);

        // 1: load 1234, busy length, commit, per-cell digits
        load(1234);
        bc = 32'(sd.busy);
        for (int i = 0; i < 20; i++) begin
            tick();
            bc += 32'(sd.busy);
        end
        chk("t1_busy_cycles", bc, 15);
        frame();
        for (int k = 0; k < 4; k++) begin
            pix_cell(k);
            chk("t1_digit", 32'(sd.digit), k + 1);
            chk("t1_inside", 32'(sd.InsideRectangle), 1);
        end

        // 2: leading blanking for 7 and 0
        load(7); run(20); frame();
        for (int k = 0; k < 4; k++) begin
            pix_cell(k);
            chk("t2_inside7", 32'(sd.InsideRectangle), (k == 3) ? 1 : 0);
        end
        chk("t2_digit7", 32'(sd.digit), 7);
        load(0); run(20); frame();
        for (int k = 0; k < 4; k++) begin
            pix_cell(k);
            chk("t2_inside0", 32'(sd.InsideRectangle), (k == 3) ? 1 : 0);
        end
        chk("t2_digit0", 32'(sd.digit), 0);

        // 3: saturation and overflow
        load(12000);
        chk("t3_ovf_set", 32'(sd.overflow), 1);
        run(20); frame(); pix_cell(0);
        chk("t3_sat_digit", 32'(sd.digit), 9);
        load(5);
        chk("t3_ovf_clr", 32'(sd.overflow), 0);
        run(20); frame();

        // 4: loads while busy, latest pending wins
        load(10); run(3); load(20); run(3); load(30); run(40); frame();
        pix_cell(2);
        chk("t4_digit", 32'(sd.digit), 3);
        pix_cell(1);
        chk("t4_blank", 32'(sd.InsideRectangle), 0);

        // 5: mid-frame result waits; result on startOfFrame cycle bypasses
        load(55); run(20); pix_cell(2);
        chk("t5_old", 32'(sd.digit), 3);
        frame(); pix_cell(2);
        chk("t5_new", 32'(sd.digit), 5);
        load(77); run(14); frame(); pix_cell(2);
        chk("t5_bypass", 32'(sd.digit), 7);

        // 6: offsets and off-area pixel
        sd.pixelX = 11'd29; sd.pixelY = 11'd13; tick();
        chk("t6_offx", 32'(sd.offsetX), 1);
        chk("t6_offy", 32'(sd.offsetY), 3);
        chk("t6_digit", 32'(sd.digit), 0);
        sd.pixelX = 11'd19; tick();
        chk("t6_outside", 32'(sd.InsideRectangle), 0);

        // reset mid-conversion aborts
        load(4321); run(5);
        reset = 1'b1;
        model_reset();
        #1;
        chk("abort_busy", 32'(sd.busy), 0);
        run(2);
        reset = 1'b0;
        run(20); frame(); pix_cell(3);
        chk("abort_digit", 32'(sd.digit), 0);
        chk("abort_inside", 32'(sd.InsideRectangle), 1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            sd.scoreLoad    = ($urandom_range(0, 19) == 0);
            sd.score        = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 16383))
                                                          : 14'($urandom_range(0, 150));
            sd.startOfFrame = ($urandom_range(0, 29) == 0);
            sd.pixelX       = 11'($urandom_range(10, 60));
            sd.pixelY       = 11'($urandom_range(5, 30));
            tick();
        end
        sd.scoreLoad = 1'b0; sd.startOfFrame = 1'b0;
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
